// File: rtl/rom_port_arbiter.sv
// Purpose : shares one 16-bit ROM port between the download packer, the main CPU fetch and the sound CPU fetch.
// Latency : a read pulses *_valid the cycle after mem_ack; a held-word hit pulses one cycle after its strobe.
// Backpres: mem_req holds until mem_ack; one pending slot per requester, and a word completing into a full write slot is dropped and flagged.
//
// Ports (suffix _i input, _o output):
//   clk_sys_i, reset_i                  clock, synchronous active-high reset
//   dl_active_i/dl_wr_i/dl_addr_i/dl_data_i, dl_overrun_o   download byte stream
//   cpu_rd_i/cpu_addr_i/cpu_do_o/cpu_valid_o                main CPU fetch
//   snd_rd_i/snd_vma_i/snd_addr_i/snd_do_o/snd_valid_o      sound CPU fetch
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_din_o/mem_dout_i/mem_ack_i  ROM port
// Optional feature macro: WORD_CACHE_EN (one held word + tag per reader).
module rom_port_arbiter #(
    parameter int MEM_AW = 16,
    parameter int CPU_AW = 16,
    parameter int SND_AW = 14,
    parameter logic [MEM_AW-1:0] SND_BASE = 16'h8000
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [MEM_AW:0]   dl_addr_i,
    input  logic [7:0]        dl_data_i,
    output logic              dl_overrun_o,
    input  logic              cpu_rd_i,
    input  logic [CPU_AW-1:0] cpu_addr_i,
    output logic [7:0]        cpu_do_o,
    output logic              cpu_valid_o,
    input  logic              snd_rd_i,
    input  logic              snd_vma_i,
    input  logic [SND_AW-1:0] snd_addr_i,
    output logic [7:0]        snd_do_o,
    output logic              snd_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [15:0]       mem_din_o,
    input  logic [15:0]       mem_dout_i,
    input  logic              mem_ack_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DL_WR  = 2'd1;
    localparam logic [1:0] S_CPU_RD = 2'd2;
    localparam logic [1:0] S_SND_RD = 2'd3;

    logic [1:0]        state_q;
    logic              dl_act_q;
    logic [7:0]        lo_q;
    logic              lo_vld_q;
    logic [MEM_AW-1:0] lo_addr_q;
    logic              wr_pend_q;
    logic [MEM_AW-1:0] wr_addr_q;
    logic [15:0]       wr_din_q;
    logic [1:0]        wr_be_q;
    logic              overrun_q;
    logic              cpu_pend_q, snd_pend_q;
    logic [MEM_AW-1:0] cpu_waddr_q, snd_waddr_q;
    logic              cpu_sel_q, snd_sel_q;
    logic              last_cpu_q;
    logic              rd_sel_q;
    logic              mem_req_q, mem_we_q;
    logic [1:0]        mem_be_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [15:0]       mem_din_q;
    logic [7:0]        cpu_do_q, snd_do_q;
    logic              cpu_valid_q, snd_valid_q;

    // Request decode
    logic              dl_rise, dl_fall, dl_even, dl_odd, flush, new_wr, wr_done, wr_full;
    logic [MEM_AW-1:0] new_wr_addr;
    logic [15:0]       new_wr_din;
    logic [1:0]        new_wr_be;
    logic [MEM_AW-1:0] cpu_waddr, snd_waddr;
    logic              snd_strobe;
    logic [7:0]        rd_byte;
    logic              cpu_hit, snd_hit;
    logic [7:0]        cpu_hit_byte, snd_hit_byte;

    assign dl_rise    = dl_active_i & ~dl_act_q;
    assign dl_fall    = ~dl_active_i & dl_act_q;
    assign dl_even    = dl_wr_i & ~dl_addr_i[0];
    assign dl_odd     = dl_wr_i & dl_addr_i[0];
    // An odd byte arriving on the falling edge pairs normally, so no flush then.
    assign flush      = dl_fall & lo_vld_q & ~dl_odd;
    assign new_wr     = dl_odd | flush;
    assign wr_done    = (state_q == S_DL_WR) & mem_ack_i;
    // The slot frees in its ack cycle, so a word completing right then is accepted.
    assign wr_full    = wr_pend_q & ~wr_done;
    assign new_wr_addr = dl_odd ? dl_addr_i[MEM_AW:1] : lo_addr_q;
    assign new_wr_din  = dl_odd ? {dl_data_i, lo_q} : {8'hFF, lo_q};
    assign new_wr_be   = dl_odd ? 2'b11 : 2'b01;
    assign cpu_waddr  = MEM_AW'(cpu_addr_i[CPU_AW-1:1]);
    assign snd_waddr  = SND_BASE + MEM_AW'(snd_addr_i[SND_AW-1:1]);
    assign snd_strobe = snd_rd_i & snd_vma_i;
    assign rd_byte    = rd_sel_q ? mem_dout_i[15:8] : mem_dout_i[7:0];

`ifdef WORD_CACHE_EN
    logic              cpu_hold_vld_q, snd_hold_vld_q;
    logic [MEM_AW-1:0] cpu_hold_tag_q, snd_hold_tag_q;
    logic [15:0]       cpu_hold_q, snd_hold_q;

    // Any write queued or in flight may alias a held word, so drop both.
    always_ff @(posedge clk_sys_i) begin
        if (reset_i || wr_pend_q || new_wr) begin
            cpu_hold_vld_q <= 1'b0;
            snd_hold_vld_q <= 1'b0;
            cpu_hold_tag_q <= '0;
            snd_hold_tag_q <= '0;
            cpu_hold_q     <= '0;
            snd_hold_q     <= '0;
        end else if (mem_ack_i && state_q == S_CPU_RD) begin
            cpu_hold_vld_q <= 1'b1;
            cpu_hold_tag_q <= mem_addr_q;
            cpu_hold_q     <= mem_dout_i;
        end else if (mem_ack_i && state_q == S_SND_RD) begin
            snd_hold_vld_q <= 1'b1;
            snd_hold_tag_q <= mem_addr_q;
            snd_hold_q     <= mem_dout_i;
        end
    end
`endif

    // A hit is only served while that requester has no fetch in flight,
    // so a hit pulse can never collide with an ack-driven pulse.
    always_comb begin
        cpu_hit      = 1'b0;
        snd_hit      = 1'b0;
        cpu_hit_byte = 8'h00;
        snd_hit_byte = 8'h00;
`ifdef WORD_CACHE_EN
        cpu_hit = cpu_hold_vld_q && (cpu_hold_tag_q == cpu_waddr) && !dl_active_i
                  && (state_q != S_CPU_RD) && !wr_pend_q;
        snd_hit = snd_hold_vld_q && (snd_hold_tag_q == snd_waddr) && !dl_active_i
                  && (state_q != S_SND_RD) && !wr_pend_q;
        cpu_hit_byte = cpu_addr_i[0] ? cpu_hold_q[15:8] : cpu_hold_q[7:0];
        snd_hit_byte = snd_addr_i[0] ? snd_hold_q[15:8] : snd_hold_q[7:0];
`endif
    end

    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            dl_act_q    <= 1'b0;
            lo_q        <= '0;
            lo_vld_q    <= 1'b0;
            lo_addr_q   <= '0;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            wr_be_q     <= '0;
            overrun_q   <= 1'b0;
            cpu_pend_q  <= 1'b0;
            snd_pend_q  <= 1'b0;
            cpu_waddr_q <= '0;
            snd_waddr_q <= '0;
            cpu_sel_q   <= 1'b0;
            snd_sel_q   <= 1'b0;
            last_cpu_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            cpu_do_q    <= '0;
            snd_do_q    <= '0;
            cpu_valid_q <= 1'b0;
            snd_valid_q <= 1'b0;
        end else begin
            dl_act_q    <= dl_active_i;
            cpu_valid_q <= 1'b0;
            snd_valid_q <= 1'b0;

            // Byte packing
            if (dl_even) begin
                lo_q      <= dl_data_i;
                lo_vld_q  <= 1'b1;
                lo_addr_q <= dl_addr_i[MEM_AW:1];
            end else if (new_wr) begin
                lo_vld_q  <= 1'b0;
            end

            // Single-entry write slot
            if (wr_done) wr_pend_q <= 1'b0;
            if (new_wr) begin
                if (wr_full) begin
                    overrun_q <= 1'b1;
                end else begin
                    wr_pend_q <= 1'b1;
                    wr_addr_q <= new_wr_addr;
                    wr_din_q  <= new_wr_din;
                    wr_be_q   <= new_wr_be;
                end
            end

            // Port FSM
            case (state_q)
                S_IDLE: begin
                    if (wr_pend_q) begin
                        state_q    <= S_DL_WR;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_be_q   <= wr_be_q;
                        mem_addr_q <= wr_addr_q;
                        mem_din_q  <= wr_din_q;
                    end else if (!dl_active_i && (cpu_pend_q || snd_pend_q)) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 2'b11;
                        mem_din_q <= '0;
                        if (cpu_pend_q && (!snd_pend_q || !last_cpu_q)) begin
                            state_q    <= S_CPU_RD;
                            mem_addr_q <= cpu_waddr_q;
                            rd_sel_q   <= cpu_sel_q;
                            cpu_pend_q <= 1'b0;
                            last_cpu_q <= 1'b1;
                        end else begin
                            state_q    <= S_SND_RD;
                            mem_addr_q <= snd_waddr_q;
                            rd_sel_q   <= snd_sel_q;
                            snd_pend_q <= 1'b0;
                            last_cpu_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (mem_ack_i) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= '0;
                        if (state_q == S_CPU_RD && !dl_active_i) begin
                            cpu_do_q    <= rd_byte;
                            cpu_valid_q <= 1'b1;
                        end
                        if (state_q == S_SND_RD && !dl_active_i) begin
                            snd_do_q    <= rd_byte;
                            snd_valid_q <= 1'b1;
                        end
                    end
                end
            endcase

            // Strobes come after the grant so one landing on a grant or ack cycle stays pending.
            if (cpu_rd_i) begin
                if (cpu_hit) begin
                    cpu_do_q    <= cpu_hit_byte;
                    cpu_valid_q <= 1'b1;
                    cpu_pend_q  <= 1'b0;
                end else begin
                    cpu_pend_q  <= 1'b1;
                    cpu_waddr_q <= cpu_waddr;
                    cpu_sel_q   <= cpu_addr_i[0];
                end
            end
            if (snd_strobe) begin
                if (snd_hit) begin
                    snd_do_q    <= snd_hit_byte;
                    snd_valid_q <= 1'b1;
                    snd_pend_q  <= 1'b0;
                end else begin
                    snd_pend_q  <= 1'b1;
                    snd_waddr_q <= snd_waddr;
                    snd_sel_q   <= snd_addr_i[0];
                end
            end

            // Reads requested before a download starts are stale once it begins.
            if (dl_rise) begin
                cpu_pend_q <= 1'b0;
                snd_pend_q <= 1'b0;
            end
        end
    end

    assign dl_overrun_o = overrun_q;
    assign cpu_do_o     = cpu_do_q;
    assign cpu_valid_o  = cpu_valid_q;
    assign snd_do_o     = snd_do_q;
    assign snd_valid_o  = snd_valid_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_din_o    = mem_din_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        dl_active = 1'b0, dl_wr = 1'b0;
    logic [16:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_overrun;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_do;
    logic        cpu_valid;
    logic        snd_rd = 1'b0, snd_vma = 1'b0;
    logic [13:0] snd_addr = '0;
    logic [7:0]  snd_do;
    logic        snd_valid;
    logic        mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_din;
    logic [15:0] mem_dout = '0;
    logic        mem_ack = 1'b0;

    rom_port_arbiter dut (
        .clk_sys_i(clk_sys), .reset_i(reset),
        .dl_active_i(dl_active), .dl_wr_i(dl_wr), .dl_addr_i(dl_addr), .dl_data_i(dl_data),
        .dl_overrun_o(dl_overrun),
        .cpu_rd_i(cpu_rd), .cpu_addr_i(cpu_addr), .cpu_do_o(cpu_do), .cpu_valid_o(cpu_valid),
        .snd_rd_i(snd_rd), .snd_vma_i(snd_vma), .snd_addr_i(snd_addr), .snd_do_o(snd_do),
        .snd_valid_o(snd_valid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_din_o(mem_din), .mem_dout_i(mem_dout), .mem_ack_i(mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    // who: 0 = write, 1 = cpu read (valid expected), 2 = snd read (valid expected), 3 = read, no valid
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] din;
        int          who;
    } mexp_t;

    mexp_t       mem_q[$];
    logic [7:0]  cpu_q[$];
    logic [7:0]  snd_q[$];
    logic [15:0] rom [logic [15:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 1;
    bit resp_en = 1'b1;
    int mem_cycles = 0;
    bit exp_cpu_pulse = 1'b0, exp_snd_pulse = 1'b0;

    function automatic logic [15:0] rom_rd(input logic [15:0] a);
        if (rom.exists(a)) return rom[a];
        return 16'h0000;
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] w, input logic sel);
        return sel ? w[15:8] : w[7:0];
    endfunction

    function automatic mexp_t mk(input logic [15:0] a, input logic we, input logic [1:0] be,
                                 input logic [15:0] din, input int who);
        mexp_t m;
        m.addr = a; m.we = we; m.be = be; m.din = din; m.who = who;
        return m;
    endfunction

    // Memory model and output scoreboard, acting on the falling edge.
    initial begin : agent
        int    wait_cnt;
        mexp_t m;
        logic [7:0] e;
        wait_cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (exp_cpu_pulse) begin
                n_cmp++;
                if (cpu_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL cpu_valid_timing: got %b want 1 one cycle after ack", cpu_valid);
                end
            end
            if (exp_snd_pulse) begin
                n_cmp++;
                if (snd_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL snd_valid_timing: got %b want 1 one cycle after ack", snd_valid);
                end
            end
            exp_cpu_pulse = 1'b0;
            exp_snd_pulse = 1'b0;
            if (cpu_valid === 1'b1) begin
                n_cmp++;
                if (cpu_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL cpu_valid_unexpected: got pulse do=%h want no pulse", cpu_do);
                end else begin
                    e = cpu_q.pop_front();
                    if (cpu_do !== e) begin
                        n_bad++;
                        $display("FAIL cpu_do: got %h want %h", cpu_do, e);
                    end
                end
            end
            if (snd_valid === 1'b1) begin
                n_cmp++;
                if (snd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL snd_valid_unexpected: got pulse do=%h want no pulse", snd_do);
                end else begin
                    e = snd_q.pop_front();
                    if (snd_do !== e) begin
                        n_bad++;
                        $display("FAIL snd_do: got %h want %h", snd_do, e);
                    end
                end
            end
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && resp_en) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    mem_cycles++;
                    n_cmp++;
                    if (mem_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL mem_cycle_unexpected: got addr=%h we=%b want no cycle",
                                 mem_addr, mem_we);
                    end else begin
                        m = mem_q.pop_front();
                        if (mem_addr !== m.addr || mem_we !== m.we ||
                            (m.we && (mem_be !== m.be || mem_din !== m.din))) begin
                            n_bad++;
                            $display("FAIL mem_cycle: got addr=%h we=%b be=%b din=%h want addr=%h we=%b be=%b din=%h",
                                     mem_addr, mem_we, mem_be, mem_din, m.addr, m.we, m.be, m.din);
                        end
                        if (m.who == 1) exp_cpu_pulse = 1'b1;
                        if (m.who == 2) exp_snd_pulse = 1'b1;
                    end
                    mem_dout = rom_rd(mem_addr);
                    mem_ack  = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; cpu_rd = 1'b0; snd_rd = 1'b0; snd_vma = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic dl_byte(input logic [16:0] a, input logic [7:0] d, input int gap);
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        tick(1);
        dl_wr = 1'b0;
        tick(gap);
    endtask

    // Bounded wait for every expected transaction to drain.
    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_sys);
            #2;
            if (mem_q.size() == 0 && cpu_q.size() == 0 && snd_q.size() == 0 && mem_req !== 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_drain: got mem=%0d cpu=%0d snd=%0d outstanding want 0",
                     name, mem_q.size(), cpu_q.size(), snd_q.size());
            mem_q.delete(); cpu_q.delete(); snd_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        @(negedge clk_sys);
        n_cmp++;
        if ({dl_overrun, cpu_valid, snd_valid, mem_req, mem_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {dl_overrun, cpu_valid, snd_valid, mem_req, mem_we});
        end
        n_cmp++;
        if ({cpu_do, snd_do, mem_be, mem_addr, mem_din} !== 50'b0) begin
            n_bad++;
            $display("FAIL reset_buses: got %h want 0", {cpu_do, snd_do, mem_be, mem_addr, mem_din});
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_pack();
        do_reset();
        ack_delay = 1;
        dl_active = 1'b1;
        tick(1);
        mem_q.push_back(mk(16'h0000, 1'b1, 2'b11, 16'h2211, 0));
        mem_q.push_back(mk(16'h0001, 1'b1, 2'b11, 16'h4433, 0));
        dl_byte(17'h0, 8'h11, 3);
        dl_byte(17'h1, 8'h22, 3);
        dl_byte(17'h2, 8'h33, 3);
        dl_byte(17'h3, 8'h44, 3);
        dl_active = 1'b0;
        wait_done("pack");
        n_cmp++;
        if (dl_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL pack_overrun: got %b want 0", dl_overrun);
        end
    endtask

    task automatic test_flush();
        do_reset();
        dl_active = 1'b1;
        tick(1);
        mem_q.push_back(mk(16'h0000, 1'b1, 2'b11, 16'h2211, 0));
        mem_q.push_back(mk(16'h0001, 1'b1, 2'b01, 16'hFF33, 0));
        dl_byte(17'h0, 8'h11, 3);
        dl_byte(17'h1, 8'h22, 3);
        dl_byte(17'h2, 8'h33, 3);
        dl_active = 1'b0;
        wait_done("flush");
    endtask

    task automatic test_arbitrate();
        do_reset();
        ack_delay = 3;
        rom[16'h0002] = 16'hA1B2;
        rom[16'h8003] = 16'hC3D4;
        mem_q.push_back(mk(16'h0002, 1'b0, 2'b11, 16'h0, 1));
        mem_q.push_back(mk(16'h8003, 1'b0, 2'b11, 16'h0, 2));
        cpu_q.push_back(pick(16'hA1B2, 1'b1));
        snd_q.push_back(pick(16'hC3D4, 1'b1));
        cpu_addr = 16'h0005; cpu_rd = 1'b1;
        snd_addr = 14'h0007; snd_rd = 1'b1; snd_vma = 1'b1;
        tick(1);
        cpu_rd = 1'b0; snd_rd = 1'b0; snd_vma = 1'b0;
        wait_done("arb_cpu_first");
        // CPU alone, then both again: sound was not last, so it goes first.
        mem_q.push_back(mk(16'h0002, 1'b0, 2'b11, 16'h0, 1));
        cpu_q.push_back(8'hA1);
        cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        wait_done("arb_cpu_alone");
        mem_q.push_back(mk(16'h8003, 1'b0, 2'b11, 16'h0, 2));
        mem_q.push_back(mk(16'h0002, 1'b0, 2'b11, 16'h0, 1));
        cpu_q.push_back(8'hA1);
        snd_q.push_back(8'hC3);
        cpu_rd = 1'b1; snd_rd = 1'b1; snd_vma = 1'b1;
        tick(1);
        cpu_rd = 1'b0; snd_rd = 1'b0; snd_vma = 1'b0;
        wait_done("arb_round_robin");
        ack_delay = 1;
    endtask

    task automatic test_vma_and_hi_byte();
        bit seen;
        do_reset();
        seen = 1'b0;
        snd_addr = 14'h0010; snd_vma = 1'b0; snd_rd = 1'b1;
        tick(1);
        snd_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (mem_req === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL vma_gate: got mem_req=1 want 0");
        end
        rom[16'h0001] = 16'hBEEF;
        mem_q.push_back(mk(16'h0001, 1'b0, 2'b11, 16'h0, 1));
        cpu_q.push_back(8'hBE);
        cpu_addr = 16'h0003; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        wait_done("hi_byte");
    endtask

    task automatic test_word_cache();
        int c0;
        do_reset();
        rom[16'h0008] = 16'h5A6B;
        mem_q.push_back(mk(16'h0008, 1'b0, 2'b11, 16'h0, 1));
        cpu_q.push_back(8'h6B);
        c0 = mem_cycles;
        cpu_addr = 16'h0010; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        wait_done("cache_first");
        cpu_q.push_back(8'h5A);
`ifdef WORD_CACHE_EN
        cpu_addr = 16'h0011; cpu_rd = 1'b1;
        @(posedge clk_sys);
        #1;
        cpu_rd = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (cpu_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL cache_hit_timing: got cpu_valid=%b want 1 one cycle after strobe", cpu_valid);
        end
        wait_done("cache_hit");
        n_cmp++;
        if (mem_cycles - c0 !== 1) begin
            n_bad++;
            $display("FAIL cache_mem_cycles: got %0d want 1", mem_cycles - c0);
        end
`else
        mem_q.push_back(mk(16'h0008, 1'b0, 2'b11, 16'h0, 1));
        cpu_addr = 16'h0011; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        wait_done("nocache_second");
        n_cmp++;
        if (mem_cycles - c0 !== 2) begin
            n_bad++;
            $display("FAIL nocache_mem_cycles: got %0d want 2", mem_cycles - c0);
        end
`endif
    endtask

    task automatic test_dl_discard();
        int c0;
        do_reset();
        ack_delay = 6;
        c0 = mem_cycles;
        mem_q.push_back(mk(16'h0002, 1'b0, 2'b11, 16'h0, 3));
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        snd_addr = 14'h0000; snd_vma = 1'b1; snd_rd = 1'b1;
        tick(1);
        snd_rd = 1'b0; snd_vma = 1'b0;
        dl_active = 1'b1;
        tick(12);
        dl_active = 1'b0;
        tick(10);
        wait_done("dl_discard");
        n_cmp++;
        if (mem_cycles - c0 !== 1) begin
            n_bad++;
            $display("FAIL dl_discard_cycles: got %0d want 1", mem_cycles - c0);
        end
        ack_delay = 1;
    endtask

    task automatic test_overrun();
        bit seen;
        do_reset();
        resp_en = 1'b0;
        dl_active = 1'b1;
        tick(1);
        dl_byte(17'h0, 8'hAA, 2);
        dl_byte(17'h1, 8'hBB, 2);
        dl_byte(17'h2, 8'hCC, 2);
        dl_byte(17'h3, 8'hDD, 2);
        @(negedge clk_sys);
        n_cmp++;
        if (dl_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b want 1", dl_overrun);
        end
        n_cmp++;
        if ({mem_req, mem_addr, mem_din} !== {1'b1, 16'h0000, 16'hBBAA}) begin
            n_bad++;
            $display("FAIL overrun_held_word: got req=%b addr=%h din=%h want req=1 addr=0000 din=bbaa",
                     mem_req, mem_addr, mem_din);
        end
        reset = 1'b1;
        dl_active = 1'b0;
        tick(1);
        reset = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if ({dl_overrun, mem_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL overrun_reset: got overrun=%b req=%b want 0 0", dl_overrun, mem_req);
        end
        resp_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (mem_req === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL overrun_dropped: got mem_req=1 after reset want 0");
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_flush();
        test_arbitrate();
        test_vma_and_hi_byte();
        test_word_cache();
        test_dl_discard();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
